// File: rtl/reg_bank_writer_pkg.sv
// reg_bank_writer_pkg: shared constants and helpers for the register-bank write path
package reg_bank_writer_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEL_W = 3;
  localparam int DEF_DEPTH = 2;
  localparam bit DEF_ZERO_REG0 = 1'b1;
  function automatic int be_w(input int width);
    return width / 8;
  endfunction
endpackage

// File: rtl/reg_bank_writer_wfifo.sv
// reg_bank_writer_wfifo: sync request FIFO (push/pop, registered full, empty, occupancy count)
module reg_bank_writer_wfifo #(
  parameter int DEPTH = 2,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] nxt;
  assign nxt = count + CW'(push) - CW'(pop);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= nxt;
      full <= nxt == CW'(DEPTH);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/reg_bank_writer.sv
// reg_bank_writer: queued, byte-masked write port of an NREGS x WIDTH register bank
module reg_bank_writer
  import reg_bank_writer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter bit ZERO_REG0 = DEF_ZERO_REG0,
  localparam int NREGS = 2 ** SEL_W,
  localparam int BE_W = be_w(WIDTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [SEL_W-1:0]       wr_sel,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [BE_W-1:0]        wr_be,
  input  logic                   hold,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic                   wr_done,
  output logic [SEL_W-1:0]       wr_done_sel,
  output logic [CW-1:0]          pending
);
  localparam int PW = SEL_W + WIDTH + BE_W;
  logic full, empty, commit;
  logic [PW-1:0] head;
  logic [SEL_W-1:0] h_sel;
  logic [WIDTH-1:0] h_data;
  logic [BE_W-1:0] h_be;
  logic [NREGS-1:0] en;
  assign wr_ready = !full;
  assign commit = !empty && !hold;
  assign {h_sel, h_data, h_be} = head;
  assign en = commit ? NREGS'(1) << h_sel : '0;
  reg_bank_writer_wfifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(wr_valid && !full),
    .pop(commit),
    .din({wr_sel, wr_data, wr_be}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(pending)
  );
  for (genvar k = 0; k < NREGS; k++) begin : g_reg
    logic [WIDTH-1:0] r;
    assign regs_flat[k*WIDTH +: WIDTH] = r;
    always_ff @(posedge clk) begin
      if (reset || (ZERO_REG0 && k == 0)) r <= '0;
      else if (en[k])
        for (int b = 0; b < BE_W; b++)
          if (h_be[b]) r[8*b +: 8] <= h_data[8*b +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_done <= 1'b0;
      wr_done_sel <= '0;
    end else begin
      wr_done <= commit;
      if (commit) wr_done_sel <= h_sel;
    end
  end
endmodule

// File: tb/tb_reg_bank_writer.sv
// tb_reg_bank_writer: randomized + directed scoreboard bench for reg_bank_writer
module tb_reg_bank_writer;
  logic clk = 0, reset = 1, wr_valid = 0, hold = 0;
  logic wr_ready, wr_done;
  logic [2:0] wr_sel = 0, wr_done_sel;
  logic [31:0] wr_data = 0;
  logic [3:0] wr_be = 0;
  logic [255:0] regs_flat;
  logic [1:0] pending;
  int total = 0, bad = 0;
  typedef struct { logic [2:0] sel; logic [31:0] val; } exp_t;
  exp_t q[$];
  logic [31:0] shadow [8];
  logic [31:0] committed [8];
  int occ = 0;
  bit exp_done = 0;
  logic [2:0] last_sel = 0;

  reg_bank_writer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .wr_be(wr_be), .hold(hold),
    .regs_flat(regs_flat), .wr_done(wr_done), .wr_done_sel(wr_done_sel),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  initial for (int k = 0; k < 8; k++) begin shadow[k] = 0; committed[k] = 0; end

  // Monitor/scoreboard: checks at negedge, then advances the reference for the coming edge.
  always @(negedge clk) begin
    chk("pending", 64'(pending), 64'(occ));
    chk("wr_ready", 64'(wr_ready), 64'(occ < 2));
    chk("wr_done", 64'(wr_done), 64'(exp_done));
    if (wr_done) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL done_without_request actual=1 required=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_done_sel", 64'(wr_done_sel), 64'(e.sel));
        committed[e.sel] = e.val;
        last_sel = e.sel;
      end
    end else chk("wr_done_sel_hold", 64'(wr_done_sel), 64'(last_sel));
    for (int k = 0; k < 8; k++) chk($sformatf("reg%0d", k), 64'(regs_flat[k*32 +: 32]), 64'(committed[k]));
    if (reset) begin
      q.delete();
      for (int k = 0; k < 8; k++) begin shadow[k] = 0; committed[k] = 0; end
      occ = 0; exp_done = 0; last_sel = 0;
    end else begin
      exp_done = occ > 0 && !hold;
      if (wr_valid && wr_ready) begin
        exp_t e;
        for (int b = 0; b < 4; b++) if (wr_be[b]) shadow[wr_sel][8*b +: 8] = wr_data[8*b +: 8];
        if (wr_sel == 0) shadow[0] = 0;
        e.sel = wr_sel; e.val = shadow[wr_sel];
        q.push_back(e);
      end
      occ = occ + int'(wr_valid && wr_ready) - int'(exp_done);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the request.
  task automatic send(input logic [2:0] s, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    wr_valid = 1; wr_sel = s; wr_data = d; wr_be = be;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      if (++n > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout actual=0 required=1");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    wr_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    // reset clears nonzero registers
    for (int k = 0; k < 8; k++) send(3'(k), $urandom | 32'h1, 4'hF);
    idle(3);
    reset = 1; idle(1); reset = 0; idle(2);
    // single full write
    send(3'd5, 32'hDEADBEEF, 4'hF);
    idle(3);
    chk("reg5_direct", 64'(regs_flat[5*32 +: 32]), 64'h0000_0000_DEAD_BEEF);
    // byte mask
    send(3'd3, 32'h11223344, 4'hF);
    send(3'd3, 32'hAABBCCDD, 4'b0101);
    idle(3);
    chk("reg3_mask", 64'(regs_flat[3*32 +: 32]), 64'h0000_0000_11BB_33DD);
    // hold fills the queue, release lets the third request in
    hold = 1;
    fork
      begin
        send(3'd1, 32'h0000_1111, 4'hF);
        send(3'd2, 32'h0000_2222, 4'hF);
        send(3'd1, 32'h0000_3333, 4'h3);
      end
      begin repeat (6) @(posedge clk); #1; hold = 0; end
    join
    idle(4);
    chk("reg1_order", 64'(regs_flat[1*32 +: 32]), 64'h0000_0000_0000_3333);
    // streaming, including the hardwired-zero register
    for (int k = 0; k < 8; k++) send(3'(k), k * 32'h01010101, 4'hF);
    idle(3);
    chk("reg7_stream", 64'(regs_flat[7*32 +: 32]), 64'h0000_0000_0707_0707);
    chk("reg0_zero", 64'(regs_flat[0 +: 32]), 64'h0);
    // reset with two queued writes drops them
    hold = 1;
    send(3'd4, 32'hCAFEF00D, 4'hF);
    send(3'd6, 32'h12345678, 4'hF);
    wr_valid = 0;
    reset = 1; idle(1); reset = 0; hold = 0; idle(3);
    chk("reg4_dropped", 64'(regs_flat[4*32 +: 32]), 64'h0);
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      hold = ($urandom_range(0, 3) == 0);
      if (!wr_ready) hold = 0;
      send(3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    hold = 0;
    idle(6);
    chk("drained", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
